// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - load-use / branch-flush / memory-busy stall control for the 5-stage core
// Optional stall and flush statistics counters are built when HAZARD_STATS_EN is defined.
module hazard_stall_controller #(
   parameter int REG_ADDR_W  = 3,
   parameter int FLUSH_DEPTH = 2,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_src1_used,
   input  logic                  id_src2_used,
   input  logic                  ex_mem_read,
   input  logic                  ex_wb,
   input  logic [REG_ADDR_W-1:0] ex_dest,
   input  logic                  branch_taken,
   input  logic                  mem_busy,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  idex_write,
   output logic                  exmem_write,
   output logic                  idex_bubble,
   output logic                  ifid_flush,
   output logic                  mem_timeout,
   output logic [15:0]           stall_count,
   output logic [15:0]           flush_count
);

   localparam int FlushW = $clog2(FLUSH_DEPTH + 1);
   localparam logic [FlushW-1:0] FlushLoad = FlushW'(FLUSH_DEPTH - 1);
   localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

   typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} stateE;

   stateE             state;
   logic [7:0]        waitCnt;
   logic [7:0]        nextWait;
   logic [FlushW-1:0] flushCnt;
   logic              memTimeout;
   logic              loadUse;
   logic              pcWr, ifidWr, idexWr, exmemWr, bubble, flush;

   always_comb begin
      loadUse = ex_mem_read & ex_wb &
                ((id_src1_used & (ex_dest == id_src1)) | (id_src2_used & (ex_dest == id_src2)));
      nextWait = (waitCnt == 8'hFF) ? 8'hFF : waitCnt + 8'd1;
      pcWr    = 1'b1;
      ifidWr  = 1'b1;
      idexWr  = 1'b1;
      exmemWr = 1'b1;
      bubble  = 1'b0;
      flush   = 1'b0;
      // MEM_WAIT without mem_busy is the release cycle and behaves exactly like RUN.
      if (mem_busy) begin
         pcWr    = 1'b0;
         ifidWr  = 1'b0;
         idexWr  = 1'b0;
         exmemWr = 1'b0;
      end else if (state == FLUSH || branch_taken) begin
         flush = 1'b1;
      end else if (loadUse) begin
         pcWr   = 1'b0;
         ifidWr = 1'b0;
         bubble = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RUN;
         waitCnt    <= 8'd0;
         flushCnt   <= '0;
         memTimeout <= 1'b0;
      end else if (state == FLUSH) begin
         // A freeze during the flush window holds the remaining flush count.
         if (!mem_busy) begin
            flushCnt <= flushCnt - 1'b1;
            if (flushCnt == 1) state <= RUN;
         end
      end else if (state == MEM_WAIT && mem_busy) begin
         waitCnt <= nextWait;
         if (nextWait == TimeoutVal) begin
            memTimeout <= 1'b1;
            state      <= RUN;
         end
      end else begin
         if (mem_busy) begin
            waitCnt <= 8'd1;
            if (TimeoutVal == 8'd1) begin
               memTimeout <= 1'b1;
               state      <= RUN;
            end else begin
               state <= MEM_WAIT;
            end
         end else if (branch_taken) begin
            flushCnt <= FlushLoad;
            state    <= (FLUSH_DEPTH > 1) ? FLUSH : RUN;
         end else begin
            state <= RUN;
         end
      end
   end

   assign pc_write    = rst_n & pcWr;
   assign ifid_write  = rst_n & ifidWr;
   assign idex_write  = rst_n & idexWr;
   assign exmem_write = rst_n & exmemWr;
   assign idex_bubble = rst_n & bubble;
   assign ifid_flush  = rst_n & flush;
   assign mem_timeout = rst_n & memTimeout;

`ifdef HAZARD_STATS_EN
   logic [15:0] stallStat;
   logic [15:0] flushStat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallStat <= 16'h0000;
         flushStat <= 16'h0000;
      end else begin
         if (!pc_write && stallStat != 16'hFFFF) stallStat <= stallStat + 16'd1;
         if (ifid_flush && flushStat != 16'hFFFF) flushStat <= flushStat + 16'd1;
      end
   end

   assign stall_count = stallStat;
   assign flush_count = flushStat;
`else
   assign stall_count = 16'h0000;
   assign flush_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed-vector bench for hazard_stall_controller
// Runs with FLUSH_DEPTH=2 and MEM_TIMEOUT=8; stats expectations follow HAZARD_STATS_EN.
module tb_hazard_stall_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] id_src1, id_src2, ex_dest;
   logic       id_src1_used, id_src2_used, ex_mem_read, ex_wb, branch_taken, mem_busy;
   logic       pc_write, ifid_write, idex_write, exmem_write, idex_bubble, ifid_flush, mem_timeout;
   logic [15:0] stall_count, flush_count;
   logic [5:0] outs;

   int totalChecks = 0;
   int passChecks = 0;

   // Enable/control vector order: pc, ifid, idex, exmem, bubble, flush.
   localparam logic [5:0] NORMAL = 6'b111100;
   localparam logic [5:0] FROZEN = 6'b000000;
   localparam logic [5:0] LU_STALL = 6'b001110;
   localparam logic [5:0] FLUSHING = 6'b111101;

   assign outs = {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, ifid_flush};

   hazard_stall_controller #(.REG_ADDR_W(3), .FLUSH_DEPTH(2), .MEM_TIMEOUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_used(id_src1_used), .id_src2_used(id_src2_used),
      .ex_mem_read(ex_mem_read), .ex_wb(ex_wb), .ex_dest(ex_dest),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
      .exmem_write(exmem_write), .idex_bubble(idex_bubble), .ifid_flush(ifid_flush),
      .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
      totalChecks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else passChecks++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_src1 = 3'd0; id_src2 = 3'd0; ex_dest = 3'd7;
      id_src1_used = 1'b0; id_src2_used = 1'b0;
      ex_mem_read = 1'b0; ex_wb = 1'b0;
      branch_taken = 1'b0; mem_busy = 1'b0;
   endtask

   task automatic setLoad(input logic [2:0] dest, input logic [2:0] s1, input logic u1,
                          input logic [2:0] s2, input logic u2, input logic wb);
      ex_mem_read = 1'b1; ex_wb = wb; ex_dest = dest;
      id_src1 = s1; id_src1_used = u1; id_src2 = s2; id_src2_used = u2;
   endtask

   initial begin
      logic [15:0] expStall, expFlush;
      idle();
      #2;
      checkVal("reset_outs", {10'd0, outs}, 16'd0);
      checkVal("reset_timeout", {15'd0, mem_timeout}, 16'd0);
      checkVal("reset_stall_cnt", stall_count, 16'd0);
      checkVal("reset_flush_cnt", flush_count, 16'd0);
      #6 rst_n = 1'b1;
      step();
      checkVal("idle_normal", {10'd0, outs}, {10'd0, NORMAL});

      // Load-use via src1, then bubble in EX.
      setLoad(3'd3, 3'd3, 1'b1, 3'd0, 1'b0, 1'b1);
      #1 checkVal("lu_src1", {10'd0, outs}, {10'd0, LU_STALL});
      step(); idle();
      #1 checkVal("lu_after", {10'd0, outs}, {10'd0, NORMAL});
      setLoad(3'd3, 3'd3, 1'b0, 3'd5, 1'b1, 1'b1);
      #1 checkVal("lu_src1_unused", {10'd0, outs}, {10'd0, NORMAL});
      setLoad(3'd4, 3'd1, 1'b1, 3'd4, 1'b1, 1'b1);
      #1 checkVal("lu_src2", {10'd0, outs}, {10'd0, LU_STALL});
      setLoad(3'd4, 3'd1, 1'b1, 3'd4, 1'b1, 1'b0);
      #1 checkVal("lu_no_wb", {10'd0, outs}, {10'd0, NORMAL});
      setLoad(3'd0, 3'd0, 1'b1, 3'd2, 1'b0, 1'b1);
      #1 checkVal("lu_r0", {10'd0, outs}, {10'd0, LU_STALL});
      step(); idle();

      // Taken branch: two flush cycles.
      branch_taken = 1'b1;
      #1 checkVal("br_c1", {10'd0, outs}, {10'd0, FLUSHING});
      step(); branch_taken = 1'b0;
      #1 checkVal("br_c2", {10'd0, outs}, {10'd0, FLUSHING});
      step();
      #1 checkVal("br_done", {10'd0, outs}, {10'd0, NORMAL});

      // Short memory freeze.
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 checkVal($sformatf("busy3_c%0d", i + 1), {10'd0, outs}, {10'd0, FROZEN});
         step();
      end
      mem_busy = 1'b0;
      #1 checkVal("busy3_resume", {10'd0, outs}, {10'd0, NORMAL});
      checkVal("busy3_no_timeout", {15'd0, mem_timeout}, 16'd0);
      step();

      // Busy + branch + load-use together: freeze first, then the branch wins.
      mem_busy = 1'b1; branch_taken = 1'b1;
      setLoad(3'd2, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1);
      #1 checkVal("combo_freeze", {10'd0, outs}, {10'd0, FROZEN});
      step(); mem_busy = 1'b0;
      #1 checkVal("combo_branch", {10'd0, outs}, {10'd0, FLUSHING});
      step(); idle();
      #1 checkVal("combo_flush2", {10'd0, outs}, {10'd0, FLUSHING});
      step();
      #1 checkVal("combo_done", {10'd0, outs}, {10'd0, NORMAL});

      // Freeze in the middle of a flush holds the remaining flush cycle.
      branch_taken = 1'b1;
      #1 step(); branch_taken = 1'b0; mem_busy = 1'b1;
      #1 checkVal("flush_frozen", {10'd0, outs}, {10'd0, FROZEN});
      step(); mem_busy = 1'b0;
      #1 checkVal("flush_resumed", {10'd0, outs}, {10'd0, FLUSHING});
      step();
      #1 checkVal("flush_resume_done", {10'd0, outs}, {10'd0, NORMAL});

      // Timeout: busy held 10 cycles, flag appears after cycle 8.
      mem_busy = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         #1 checkVal($sformatf("to_outs_c%0d", i), {10'd0, outs}, {10'd0, FROZEN});
         checkVal($sformatf("to_flag_c%0d", i), {15'd0, mem_timeout}, (i >= 9) ? 16'd1 : 16'd0);
         step();
      end
      mem_busy = 1'b0;
      #1 checkVal("to_after_outs", {10'd0, outs}, {10'd0, NORMAL});
      step(); step();
      checkVal("to_sticky", {15'd0, mem_timeout}, 16'd1);

      // Reset mid-flush.
      branch_taken = 1'b1;
      #1 step(); branch_taken = 1'b0;
      #1 checkVal("pre_reset_flush", {10'd0, outs}, {10'd0, FLUSHING});
      rst_n = 1'b0;
      #1 checkVal("reset_mid_outs", {10'd0, outs}, 16'd0);
      checkVal("reset_mid_timeout", {15'd0, mem_timeout}, 16'd0);
      rst_n = 1'b1;
      #1 checkVal("post_reset_run", {10'd0, outs}, {10'd0, NORMAL});
      checkVal("post_reset_stall_cnt", stall_count, 16'd0);
      checkVal("post_reset_flush_cnt", flush_count, 16'd0);
      step();
      checkVal("post_reset_no_flush", {10'd0, outs}, {10'd0, NORMAL});
      checkVal("post_reset_timeout", {15'd0, mem_timeout}, 16'd0);

      // Statistics: one load-use stall, one 2-cycle flush, one busy cycle.
      setLoad(3'd1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1);
      step(); idle();
      branch_taken = 1'b1;
      #1 step(); branch_taken = 1'b0;
      #1 step();
      mem_busy = 1'b1;
      #1 step(); mem_busy = 1'b0;
      #1 step();
`ifdef HAZARD_STATS_EN
      expStall = 16'd2;
      expFlush = 16'd2;
`else
      expStall = 16'd0;
      expFlush = 16'd0;
`endif
      checkVal("stats_stall", stall_count, expStall);
      checkVal("stats_flush", flush_count, expFlush);

      $display("%0d/%0d checks passed", passChecks, totalChecks);
      $finish;
   end

endmodule
